// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned        INSTR_W   = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] PC_INCR   = 32'd4;

  // One buffered fetch result: the address it came from and the returned word.
  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] word;
  } fetch_entry_t;

  // 32-bit add that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, simultaneous push/pop at any occupancy
// (including full) and an occupancy count. DEPTH must be a power of 2.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so push is legal even when full.
  assign do_push = push_i && (!full || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage array: written on push, never flushed.
  // NOTE: the data array has no reset on purpose; pointers/count define validity,
  // so resetting the storage would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, issues in-order instruction memory requests,
// buffers returned words and presents one instruction per cycle to decode.
// Optional macro FETCH_STATS_EN adds saturating FetchCount/FlushCount outputs.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemRdy,
  input  logic        IMemValid,
  input  logic [31:0] IMemData,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        Stall,
  output logic [31:0] Instruction,
  output logic [31:0] InstPC,
  output logic [31:0] NextInstruct,
  output logic        InstValid
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] FlushCount
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] occ;
  logic [CNT_W:0]   inflight;
  logic             issue_fire;
  logic             resp_ok;
  logic             resp_keep;
  logic             q_pop;
  logic             q_empty;
  fetch_entry_t     q_wdata, q_head;
  logic [31:0]      tag_head;
  logic             tag_empty;
  logic [CNT_W-1:0] tag_cnt_unused;

  // Queued entries plus requests still in memory may never exceed DEPTH,
  // which is what guarantees the queue cannot overflow.
  assign inflight   = {1'b0, occ} + {1'b0, out_cnt_q};
  assign IMemReq    = Reset && !Redirect && (inflight < (CNT_W+1)'(DEPTH));
  assign IMemAddr   = fetch_pc_q;
  assign issue_fire = IMemReq && IMemRdy;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_ok   = IMemValid && (out_cnt_q != '0);
  // Keep only right-path responses; anything returning during a redirect is wrong-path.
  assign resp_keep = resp_ok && (drop_cnt_q == '0) && !Redirect && !tag_empty;
  assign q_pop     = InstValid && !Stall && !Redirect;

  assign q_wdata.pc   = tag_head;
  assign q_wdata.word = IMemData;

  // Addresses of issued, not-yet-returned, right-path requests.
  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (Clk),
    .rst_n   (Reset),
    .flush_i (Redirect),
    .push_i  (issue_fire),
    .wdata_i (fetch_pc_q),
    .pop_i   (resp_keep),
    .rdata_o (tag_head),
    .count_o (tag_cnt_unused),
    .empty_o (tag_empty)
  );

  // Returned instructions waiting for decode.
  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_data_fifo (
    .clk     (Clk),
    .rst_n   (Reset),
    .flush_i (Redirect),
    .push_i  (resp_keep),
    .wdata_i (q_wdata),
    .pop_i   (q_pop),
    .rdata_o (q_head),
    .count_o (occ),
    .empty_o (q_empty)
  );

  // Next fetch PC and outstanding/drop counters; redirect overrides everything.
  // NOTE: every variable assigned in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_cnt_d  = out_cnt_q + CNT_W'(issue_fire) - CNT_W'(resp_ok);
    drop_cnt_d = drop_cnt_q;
    if (Redirect) begin
      fetch_pc_d = RedirectPC;
      // Every request still in memory after this cycle becomes wrong-path.
      drop_cnt_d = out_cnt_q - CNT_W'(resp_ok);
    end else begin
      if (issue_fire) fetch_pc_d = fetch_pc_q + PC_INCR;
      if (resp_ok && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  // Fetch PC and request counters.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fetch_pc_q <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Decode-facing view of the queue head; an empty queue reads as a NOP bubble.
  assign InstValid    = !q_empty;
  assign Instruction  = InstValid ? q_head.word : NOP_INSTR;
  assign InstPC       = InstValid ? q_head.pc   : 32'h0000_0000;
  assign NextInstruct = InstPC + PC_INCR;

  // Simulation-only check for responses with nothing outstanding.
  always @(posedge Clk) begin
    if (Reset) begin
      assert (!(IMemValid && (out_cnt_q == '0)))
        else $warning("instr_fetch_queue: IMemValid with no outstanding request ignored");
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] flush_count_q, flush_count_d;
  logic [31:0] flush_amt;

  // Discarded at a redirect: queued entries plus requests not already marked for drop.
  assign flush_amt = 32'(occ) + 32'(out_cnt_q) - 32'(drop_cnt_q);

  // Saturating statistics update.
  always_comb begin
    fetch_count_d = fetch_count_q;
    flush_count_d = flush_count_q;
    if (q_pop)    fetch_count_d = sat_add32(fetch_count_q, 32'd1);
    if (Redirect) flush_count_d = sat_add32(flush_count_q, flush_amt);
  end

  // Statistics registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign FetchCount = fetch_count_q;
  assign FlushCount = flush_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue (DEPTH=4, RESET_PC=0). Memory responses
// are driven by hand each cycle; inputs change and outputs are sampled just
// after the falling edge.
module tb_instr_fetch_queue;

  logic        Clk;
  logic        Reset;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemRdy;
  logic        IMemValid;
  logic [31:0] IMemData;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        Stall;
  logic [31:0] Instruction;
  logic [31:0] InstPC;
  logic [31:0] NextInstruct;
  logic        InstValid;
`ifdef FETCH_STATS_EN
  logic [31:0] FetchCount;
  logic [31:0] FlushCount;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int nreq;

  instr_fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemRdy      (IMemRdy),
    .IMemValid    (IMemValid),
    .IMemData     (IMemData),
    .Redirect     (Redirect),
    .RedirectPC   (RedirectPC),
    .Stall        (Stall),
    .Instruction  (Instruction),
    .InstPC       (InstPC),
    .NextInstruct (NextInstruct),
    .InstValid    (InstValid)
`ifdef FETCH_STATS_EN
    ,
    .FetchCount   (FetchCount),
    .FlushCount   (FlushCount)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, apply inputs for that cycle, let them settle.
  task automatic drive(input logic rdy, input logic vld, input logic [31:0] data,
                       input logic stall, input logic redir, input logic [31:0] rpc);
    @(negedge Clk);
    IMemRdy    = rdy;
    IMemValid  = vld;
    IMemData   = data;
    Stall      = stall;
    Redirect   = redir;
    RedirectPC = rpc;
    #1;
  endtask

  initial begin
    Reset = 1'b0; IMemRdy = 1'b0; IMemValid = 1'b0; IMemData = '0;
    Stall = 1'b0; Redirect = 1'b0; RedirectPC = '0;
    #1;
    // ---- reset state
    check("rst_req",   32'(IMemReq),   32'h0);
    check("rst_valid", 32'(InstValid), 32'h0);
    check("rst_instr", Instruction,    32'h0);
    check("rst_pc",    InstPC,         32'h0);
    check("rst_next",  NextInstruct,   32'h4);
    check("rst_addr",  IMemAddr,       32'h0);

    // ---- basic 1-cycle-latency fetch
    drive(1, 0, 32'h0, 0, 0, 32'h0); Reset = 1'b1; #1;           // A: issue 0
    check("a_req",  32'(IMemReq), 32'h1);
    check("a_addr", IMemAddr,     32'h0);
    drive(1, 1, 32'h2008_0005, 0, 0, 32'h0);                     // B: resp 0, issue 4
    check("b_addr",  IMemAddr,     32'h4);
    check("b_valid", 32'(InstValid), 32'h0);
    drive(0, 1, 32'h2009_0007, 0, 0, 32'h0);                     // C: resp 4, rdy low 1
    check("c_instr", Instruction,  32'h2008_0005);
    check("c_pc",    InstPC,       32'h0);
    check("c_next",  NextInstruct, 32'h4);
    check("c_addr",  IMemAddr,     32'h8);
    drive(0, 0, 32'h0, 0, 0, 32'h0);                             // D: rdy low 2
    check("d_instr", Instruction,  32'h2009_0007);
    check("d_pc",    InstPC,       32'h4);
    check("d_next",  NextInstruct, 32'h8);
    drive(0, 0, 32'h0, 0, 0, 32'h0);                             // E: rdy low 3
    check("e_valid", 32'(InstValid), 32'h0);
    check("e_instr", Instruction,  32'h0);
    check("e_addr",  IMemAddr,     32'h8);
    drive(0, 0, 32'h0, 0, 0, 32'h0);                             // F: rdy low 4
    check("f_addr",  IMemAddr,     32'h8);
    drive(0, 0, 32'h0, 0, 0, 32'h0);                             // G: rdy low 5
    check("g_addr",  IMemAddr,     32'h8);
    check("g_req",   32'(IMemReq), 32'h1);
    drive(1, 0, 32'h0, 0, 0, 32'h0);                             // H: resume at 8
    check("h_addr",  IMemAddr,     32'h8);
    drive(0, 1, 32'hAAAA_0008, 0, 0, 32'h0);                     // I: resp 8
    check("i_addr",  IMemAddr,     32'hC);
    drive(0, 0, 32'h0, 0, 0, 32'h0);                             // J
    check("j_instr", Instruction,  32'hAAAA_0008);
    check("j_pc",    InstPC,       32'h8);
    check("j_next",  NextInstruct, 32'hC);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    check("k_valid", 32'(InstValid), 32'h0);

    // ---- reset pulse, then stall with a full queue
    drive(0, 0, 32'h0, 0, 0, 32'h0); Reset = 1'b0; #1;
    drive(0, 0, 32'h0, 0, 0, 32'h0); Reset = 1'b1; #1;
    nreq = 0;
    for (int k = 1; k <= 10; k++) begin
      drive(1, (k >= 2 && k <= 5), 32'h1000_0000 | 32'(4 * (k - 2)), 1, 0, 32'h0);
      if (IMemReq) nreq++;
    end
    check("stall_nreq",  32'(nreq),      32'd4);
    check("stall_req",   32'(IMemReq),   32'h0);
    check("stall_valid", 32'(InstValid), 32'h1);
    check("stall_pc",    InstPC,         32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 32'h0, 0, 0, 32'h0);
      check("drain_pc",    InstPC,      32'(4 * i));
      check("drain_instr", Instruction, 32'h1000_0000 | 32'(4 * i));
    end
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    check("drain_empty", 32'(InstValid), 32'h0);

    // ---- redirect with 3 outstanding and 1 queued (PC continues at 16)
    drive(1, 0, 32'h0, 1, 0, 32'h0);                             // issue 16
    check("r1_addr", IMemAddr, 32'h10);
    drive(1, 1, 32'h1000_0010, 1, 0, 32'h0);                     // resp 16, issue 20
    drive(1, 0, 32'h0, 1, 0, 32'h0);                             // issue 24
    drive(1, 0, 32'h0, 1, 0, 32'h0);                             // issue 28
    check("r4_pc",   InstPC,   32'h10);
    check("r4_addr", IMemAddr, 32'h1C);
    drive(1, 0, 32'h0, 1, 1, 32'h40);                            // redirect
    check("r5_req",  32'(IMemReq), 32'h0);
    drive(1, 1, 32'hDEAD_0020, 0, 0, 32'h0);                     // late 20, issue 0x40
    check("r6_valid", 32'(InstValid), 32'h0);
    check("r6_instr", Instruction,    32'h0);
    check("r6_addr",  IMemAddr,       32'h40);
    check("r6_req",   32'(IMemReq),   32'h1);
    drive(1, 1, 32'hDEAD_0024, 0, 0, 32'h0);                     // late 24, issue 0x44
    check("r7_valid", 32'(InstValid), 32'h0);
    check("r7_addr",  IMemAddr,       32'h44);
    drive(1, 1, 32'hDEAD_0028, 0, 0, 32'h0);                     // late 28, issue 0x48
    check("r8_valid", 32'(InstValid), 32'h0);
    drive(0, 1, 32'h1000_0040, 0, 0, 32'h0);                     // resp 0x40
    check("r9_valid", 32'(InstValid), 32'h0);
    drive(0, 1, 32'h1000_0044, 0, 0, 32'h0);                     // resp 0x44
    check("r10_instr", Instruction,  32'h1000_0040);
    check("r10_pc",    InstPC,       32'h40);
    check("r10_next",  NextInstruct, 32'h44);
    drive(0, 1, 32'h1000_0048, 0, 0, 32'h0);                     // resp 0x48
    check("r11_instr", Instruction,  32'h1000_0044);
    check("r11_pc",    InstPC,       32'h44);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    check("r12_pc",    InstPC,       32'h48);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    check("r13_valid", 32'(InstValid), 32'h0);

    // ---- reset mid-stream with 2 outstanding, then a stray response
    drive(1, 0, 32'h0, 0, 0, 32'h0);                             // issue 0x4C
    check("m1_addr", IMemAddr, 32'h4C);
    drive(1, 0, 32'h0, 0, 0, 32'h0);                             // issue 0x50
    drive(0, 0, 32'h0, 0, 0, 32'h0); Reset = 1'b0; #1;
    check("mrst_req",   32'(IMemReq),   32'h0);
    check("mrst_addr",  IMemAddr,       32'h0);
    check("mrst_valid", 32'(InstValid), 32'h0);
    drive(0, 1, 32'hBAD0_BAD0, 0, 0, 32'h0); Reset = 1'b1; #1;  // stray response
    check("m4_addr", IMemAddr,     32'h0);
    check("m4_req",  32'(IMemReq), 32'h1);
    drive(1, 0, 32'h0, 0, 0, 32'h0);                             // issue RESET_PC
    check("m5_valid", 32'(InstValid), 32'h0);
    check("m5_addr",  IMemAddr,       32'h0);
    drive(0, 1, 32'h1000_0000, 0, 0, 32'h0);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    check("m7_instr", Instruction, 32'h1000_0000);
    check("m7_pc",    InstPC,      32'h0);

`ifdef FETCH_STATS_EN
    // ---- statistics: 6 dequeues, then redirect dropping 2 queued + 1 outstanding
    drive(0, 0, 32'h0, 0, 0, 32'h0); Reset = 1'b0; #1;
    check("st_rst_fetch", FetchCount, 32'h0);
    check("st_rst_flush", FlushCount, 32'h0);
    drive(0, 0, 32'h0, 0, 0, 32'h0); Reset = 1'b1; #1;
    for (int k = 0; k < 8; k++) begin
      drive(1, (k >= 1), 32'h1000_0000 | 32'(4 * (k - 1)), 0, 0, 32'h0);
    end
    drive(1, 1, 32'h1000_001C, 1, 0, 32'h0);
    check("st_pre_fetch", FetchCount, 32'd6);
    drive(0, 0, 32'h0, 1, 1, 32'h80);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    check("st_fetch", FetchCount, 32'd6);
    check("st_flush", FlushCount, 32'd3);
    check("st_valid", 32'(InstValid), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
